// File: rtl/exe_muldiv_pkg.sv
`default_nettype none
// exe_muldiv_pkg: shared widths, instruction ids and FSM encoding for the EXE-stage muldiv unit.
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif

package exe_muldiv_pkg;

  localparam int INST_ID_W = `INST_ID_LEN;

  typedef enum logic [INST_ID_W-1:0] {
    ID_NOP    = 6'd0,
    ID_ADD    = 6'd1,
    ID_SUB    = 6'd2,
    ID_AND    = 6'd3,
    ID_OR     = 6'd4,
    ID_LW     = 6'd5,
    ID_SW     = 6'd6,
    ID_BEQ    = 6'd7,
    ID_MUL    = 6'd40,
    ID_MULH   = 6'd41,
    ID_MULHSU = 6'd42,
    ID_MULHU  = 6'd43,
    ID_DIV    = 6'd44,
    ID_DIVU   = 6'd45,
    ID_REM    = 6'd46,
    ID_REMU   = 6'd47
  } instr_id_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_md_op(input logic [INST_ID_W-1:0] id);
    return id inside {ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
                      ID_DIV, ID_DIVU, ID_REM, ID_REMU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_muldiv_core.sv
`default_nettype none
// exe_muldiv_core: radix-2 unsigned datapath, shift-add multiply or restoring divide, one bit per step.
module exe_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_prod,
  output logic [XLEN-1:0]   o_quot,
  output logic [XLEN-1:0]   o_rem
);

  // r_hi: product high half / partial remainder; r_lo: multiplier / quotient.
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_ge    = w_shift[XLEN] | ~w_diff[XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_prod = {r_hi, r_lo};
  assign o_quot = r_lo;
  assign o_rem  = r_hi;

endmodule
`default_nettype wire

// File: rtl/exe_muldiv.sv
`default_nettype none
// exe_muldiv: RV32M multiply/divide unit in EXE; stalls ID/EXE while iterating, one result per M op.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN  = `GPR_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [`INST_ID_LEN-1:0]    instr_id_i,
  input  logic [XLEN-1:0]            rs1_val_i,
  input  logic [XLEN-1:0]            rs2_val_i,
  input  logic [`GPR_ADDR_SPACE-1:0] rd_addr_i,
  input  logic                       rd_we_i,
  output logic                       stall_o,
  output logic                       result_valid_o,
  output logic [XLEN-1:0]            result_o,
  output logic [`GPR_ADDR_SPACE-1:0] rd_addr_o,
  output logic                       rd_we_o
);

  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  instr_id_e                  r_op;
  logic [`GPR_ADDR_SPACE-1:0] r_rd_addr;
  logic                       r_rd_we, r_neg, r_is_div, r_special;
  logic [XLEN-1:0]            r_special_res;

  logic                       w_is_md, w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic                       w_is_div, w_is_rem, w_div0, w_ovf, w_special, w_start, w_step;
  logic [XLEN-1:0]            w_abs1, w_abs2, w_special_res, w_res;
  logic [XLEN-1:0]            w_quot, w_rem, w_quot_fix, w_rem_fix;
  logic [2*XLEN-1:0]          w_prod, w_prod_fix;

  always_comb begin
    w_is_md   = is_md_op(instr_id_i);
    w_sgn1    = instr_id_i inside {ID_MUL, ID_MULH, ID_MULHSU, ID_DIV, ID_REM};
    w_sgn2    = instr_id_i inside {ID_MUL, ID_MULH, ID_DIV, ID_REM};
    w_is_div  = instr_id_i inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
    w_is_rem  = instr_id_i inside {ID_REM, ID_REMU};
    w_neg1    = w_sgn1 & rs1_val_i[XLEN-1];
    w_neg2    = w_sgn2 & rs2_val_i[XLEN-1];
    w_abs1    = w_neg1 ? -rs1_val_i : rs1_val_i;
    w_abs2    = w_neg2 ? -rs2_val_i : rs2_val_i;
    w_div0    = w_is_div & (rs2_val_i == '0);
    w_ovf     = (instr_id_i inside {ID_DIV, ID_REM}) &
                (rs1_val_i == C_INT_MIN) & (rs2_val_i == '1);
    w_special = w_div0 | w_ovf;
    if (w_div0) w_special_res = w_is_rem ? rs1_val_i : '1;
    else        w_special_res = w_is_rem ? '0 : C_INT_MIN;
    w_start   = (r_state == ST_IDLE) & w_is_md & ~flush_i & ~w_special;
    w_step    = (r_state == ST_CALC);
  end

  exe_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_load   (w_start),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (w_abs1),
    .i_b      (w_abs2),
    .o_prod   (w_prod),
    .o_quot   (w_quot),
    .o_rem    (w_rem)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_op          <= ID_NOP;
      r_rd_addr     <= '0;
      r_rd_we       <= 1'b0;
      r_neg         <= 1'b0;
      r_is_div      <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_md && !flush_i) begin
            r_op          <= instr_id_e'(instr_id_i);
            r_rd_addr     <= rd_addr_i;
            r_rd_we       <= rd_we_i;
            // Remainder takes the dividend's sign; products and quotients the XOR.
            r_neg         <= w_is_rem ? w_neg1 : (w_neg1 ^ w_neg2);
            r_is_div      <= w_is_div;
            r_special     <= w_special;
            r_special_res <= w_special_res;
            r_cnt         <= '0;
            r_state       <= w_special ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN-1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_prod_fix = r_neg ? -w_prod : w_prod;
    w_quot_fix = r_neg ? -w_quot : w_quot;
    w_rem_fix  = r_neg ? -w_rem  : w_rem;
    case (r_op)
      ID_MUL:                       w_res = w_prod_fix[XLEN-1:0];
      ID_MULH, ID_MULHSU, ID_MULHU: w_res = w_prod_fix[2*XLEN-1:XLEN];
      ID_DIV, ID_DIVU:              w_res = w_quot_fix;
      default:                      w_res = w_rem_fix;
    endcase
    if (r_special) w_res = r_special_res;
  end

  always_comb begin
    case (r_state)
      ST_IDLE: stall_o = w_is_md & ~flush_i;
      ST_CALC: stall_o = ~flush_i;
      default: stall_o = 1'b0;
    endcase
    stall_o        = stall_o & rst_ni;
    result_valid_o = (r_state == ST_DONE) & ~flush_i;
    result_o       = result_valid_o ? w_res : '0;
    rd_we_o        = r_rd_we & result_valid_o;
    rd_addr_o      = r_rd_addr;
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`default_nettype none
// tb_exe_muldiv: directed plus randomized checks of exe_muldiv against an arithmetic reference model.
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  instr_id_i = ID_NOP;
  logic [31:0] rs1_val_i = '0, rs2_val_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic        stall_o, result_valid_o, rd_we_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_vec = 0;
  int n_err = 0;

  exe_muldiv dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .instr_id_i(instr_id_i),
    .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .stall_o(stall_o), .result_valid_o(result_valid_o), .result_o(result_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [5:0] id, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 0;
    case (id)
      ID_MUL:    p = sa * sb;
      ID_MULH:   p = (sa * sb) >>> 32;
      ID_MULHSU: p = (sa * ub) >>> 32;
      ID_MULHU:  p = (ua * ub) >> 32;
      ID_DIV:    if (b == 0) p = -1; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = sa; else p = sa / sb;
      ID_REM:    if (b == 0) p = sa; else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = 0; else p = sa % sb;
      ID_DIVU:   if (b == 0) p = -1; else p = ua / ub;
      ID_REMU:   if (b == 0) p = ua; else p = ua % ub;
      default:   p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_stalls(input logic [5:0] id, input logic [31:0] a, input logic [31:0] b);
    logic is_div, ovf;
    is_div = id inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
    ovf    = (id inside {ID_DIV, ID_REM}) && a == 32'h80000000 && b == 32'hFFFFFFFF;
    return (is_div && b == 0) || ovf ? 1 : 33;
  endfunction

  // Entered #1 after a posedge; returns #1 after the posedge that ends the DONE cycle.
  task automatic do_op(input string tag, input logic [5:0] id, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic we,
                       output logic [31:0] res);
    int stalls;
    logic got, first_stall, stall_in_done;
    logic [4:0] rd_o;
    logic we_o;
    instr_id_i = id; rs1_val_i = a; rs2_val_i = b; rd_addr_i = rd; rd_we_i = we;
    stalls = 0; got = 0; first_stall = 0; stall_in_done = 0; res = '0; rd_o = '0; we_o = 0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      @(negedge clk_i);
      if (result_valid_o) begin
        got = 1; res = result_o; rd_o = rd_addr_o; we_o = rd_we_o; stall_in_done = stall_o;
      end else if (stall_o) begin
        if (cyc == 0) first_stall = 1;
        stalls++;
      end
      @(posedge clk_i); #1;
    end
    check({tag, " valid"}, 32'(got), 32'd1);
    check({tag, " result"}, res, model(id, a, b));
    check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls(id, a, b)));
    check({tag, " first_stall"}, 32'(first_stall), 32'd1);
    check({tag, " done_stall"}, 32'(stall_in_done), 32'd0);
    check({tag, " rd_addr"}, 32'(rd_o), 32'(rd));
    check({tag, " rd_we"}, 32'(we_o), 32'(we));
  endtask

  task automatic idle_no_result(input string tag, input int n);
    int seen_valid, seen_stall;
    seen_valid = 0; seen_stall = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (result_valid_o) seen_valid++;
      if (stall_o) seen_stall++;
      @(posedge clk_i); #1;
    end
    check({tag, " no_valid"}, 32'(seen_valid), 32'd0);
    check({tag, " no_stall"}, 32'(seen_stall), 32'd0);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [5:0]  id;
    logic [5:0]  md_ids [8];
    md_ids = '{ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU, ID_DIV, ID_DIVU, ID_REM, ID_REMU};

    instr_id_i = ID_ADD;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset stall", 32'(stall_o), 32'd0);
    check("reset valid", 32'(result_valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", 32'(rd_addr_o), 32'd0);
    check("reset we", 32'(rd_we_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle_no_result("non-M idle", 3);

    do_op("MUL 7x-3", ID_MUL, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b1, res);
    check("MUL const", res, 32'hFFFFFFEB);
    instr_id_i = ID_ADD; @(posedge clk_i); #1;
    do_op("MULHU", ID_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, res);
    check("MULHU const", res, 32'hFFFFFFFE);
    do_op("MULHSU", ID_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b0, res);
    check("MULHSU const", res, 32'hFFFFFFFF);
    do_op("DIV -7/2", ID_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1, res);
    check("DIV const", res, 32'hFFFFFFFD);
    do_op("REM -7/2", ID_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 1'b1, res);
    check("REM const", res, 32'hFFFFFFFF);
    do_op("DIVU /0", ID_DIVU, 32'd100, 32'd0, 5'd7, 1'b1, res);
    check("DIVU0 const", res, 32'hFFFFFFFF);
    do_op("REMU /0", ID_REMU, 32'd100, 32'd0, 5'd8, 1'b1, res);
    check("REMU0 const", res, 32'd100);
    do_op("DIV ovf", ID_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b1, res);
    check("DIVovf const", res, 32'h80000000);
    do_op("REM ovf", ID_REM, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b1, res);
    check("REMovf const", res, 32'd0);

    // Flush in the 10th CALC cycle.
    instr_id_i = ID_MUL; rs1_val_i = 32'd1234; rs2_val_i = 32'd5678; rd_addr_i = 5'd12; rd_we_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush stall", 32'(stall_o), 32'd0);
    check("flush valid", 32'(result_valid_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    instr_id_i = ID_ADD;
    idle_no_result("post-flush", 40);
    do_op("MUL after flush", ID_MUL, 32'd5, 32'd6, 5'd13, 1'b1, res);

    // Reset in the 5th CALC cycle.
    instr_id_i = ID_MUL; rs1_val_i = 32'h12345; rs2_val_i = 32'h777; rd_addr_i = 5'd21; rd_we_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (4) begin @(posedge clk_i); #1; end
    rst_ni = 1'b0;
    #1;
    check("rst stall", 32'(stall_o), 32'd0);
    check("rst valid", 32'(result_valid_o), 32'd0);
    check("rst result", result_o, 32'd0);
    check("rst rd", 32'(rd_addr_o), 32'd0);
    check("rst we", 32'(rd_we_o), 32'd0);
    instr_id_i = ID_ADD;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle_no_result("post-reset", 40);
    do_op("MUL 3x4", ID_MUL, 32'd3, 32'd4, 5'd1, 1'b1, res);
    check("MUL3x4 const", res, 32'd12);

    for (int n = 0; n < 40; n++) begin
      id = md_ids[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: b = 32'(-$signed(32'($urandom_range(1, 9))));
        default: ;
      endcase
      do_op("random", id, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), res);
      if ($urandom_range(0, 2) == 0) begin
        instr_id_i = ID_SUB;
        @(posedge clk_i); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- RV32M multiply/divide unit in the EXE stage. Consumes the ID/EXE pipeline register outputs: operand values after forwarding, instruction id, rd address and rd write enable.
- Iterative radix-2 datapath, one bit per cycle. Holds the pipeline by raising stall_o to the hazard detection unit, which keeps ID/EXE in Stall mode.
- Delivers one result per M-type instruction to the EXE result mux.

Parameters:
- XLEN, `GPR_WIDTH (32): operand/result width.
- CNT_W, 6: iteration counter width; must hold XLEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort in-flight op (branch/trap flush of EXE)
- instr_id_i  in  `INST_ID_LEN  instruction id from ID/EXE
- rs1_val_i  in  XLEN  forwarded rs1 value
- rs2_val_i  in  XLEN  forwarded rs2 value
- rd_addr_i  in  `GPR_ADDR_SPACE  destination register
- rd_we_i  in  1  destination write enable
- stall_o  out  1  request ID/EXE Stall and freeze upstream
- result_valid_o  out  1  result_o valid this cycle
- result_o  out  XLEN  M-extension result
- rd_addr_o  out  `GPR_ADDR_SPACE  latched rd for the result
- rd_we_o  out  1  latched rd_we, qualified by result_valid_o

Behaviour:
- Reset (rst_ni=0, async): state=IDLE, counter=0, operand/accumulator regs=0, all outputs 0.
- is_md is high when instr_id_i is one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - stall_o = is_md (combinational).
  - If is_md and !flush_i: latch op, rd_addr, rd_we and |operands| per signedness. Signed ops negate negative operands; MULHSU treats rs2 as unsigned. Latch the result negate flag.
  - Multiply or normal divide: go to CALC, counter=0.
  - Divide by zero or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF for DIV/REM): latch the special result and go straight to DONE.
- CALC:
  - stall_o=1.
  - Multiply: 2·XLEN shift-add accumulator.
  - Divide: restoring shift-subtract, giving quotient and remainder.
  - counter++ each cycle; after XLEN iterations (counter==XLEN-1 at the edge) go to DONE.
- DONE:
  - stall_o=0 and result_valid_o=1 for exactly one cycle. Return to IDLE unconditionally.
  - result_o is the sign-fixed selection:
    - MUL: low word.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder. Remainder sign follows the dividend.
  - ID/EXE advances on this same edge, so the instruction just completed is never restarted.
- Latency:
  - Normal op: stall_o high for XLEN+1 cycles (IDLE detect plus XLEN CALC cycles); result on the next cycle.
  - Special case: stall 1 cycle; result on the next cycle.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- flush_i:
  - In IDLE: no start, stall_o=0.
  - In CALC: next state IDLE, result_valid_o never asserted, stall_o drops the same cycle (combinational).
  - In DONE: result_valid_o forced 0.
- Back-to-back M ops: the second op is detected in the IDLE cycle right after DONE. There are no bubbles beyond the DONE cycle.
- Non-M instructions in IDLE: stall_o=0, result_valid_o=0, no state change.
- Reset asserted mid-CALC: immediate return to IDLE with zeroed outputs, and no result is produced.

Decomposition:
- Shared package/defines:
  - The eight M-extension instr_id encodings alongside the existing `INST_ID_LEN ids.
  - FSM state encodings.
  - Existing `GPR_WIDTH and `GPR_ADDR_SPACE.
- Optional sub-module muldiv_core: the iterative shift-add/shift-subtract datapath with start/done.
- exe_muldiv keeps the FSM, the operand sign handling and the result selection.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: stall_o high 33 cycles, then result_valid_o=1 for 1 cycle with result_o=0xFFFFFFEB and rd_addr_o/rd_we_o matching the inputs.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF gives 0xFFFFFFFF.
- DIV −7/2 gives 0xFFFFFFFD; REM −7/2 gives 0xFFFFFFFF. Issued back-to-back: the second stall starts the cycle after the first DONE.
- Special cases, each with 1 stall cycle then result:
  - DIVU 100/0 gives 0xFFFFFFFF; REMU 100/0 gives 100.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- flush_i pulsed in CALC cycle 10: stall_o low that cycle, FSM in IDLE next cycle, and result_valid_o stays 0 for 40 cycles.
- rst_ni low during CALC cycle 5: all outputs 0 immediately. After release, ADD instr_id gives stall_o=0; then a new MUL 3×4 gives 12.
